tx_frame_buf: RTL

TX_FRAME_BUF -- requirements
Module: tx_frame_buf

---
 rtl/cdbus_pkg.sv | 15 +
 rtl/tx_buf_ram.sv | 47 ++++
 rtl/tx_frame_buf.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cdbus_pkg.sv
// ---------------------------------------------------------------------------
// cdbus_pkg -- shared constants and helpers for the CDBUS transmit path.
//   PAGE_AW    : byte-offset width inside one 256-byte frame page.
//   page_idx_w : width of a page index / committed-page counter for a
//                given number of pages.
// ---------------------------------------------------------------------------
package cdbus_pkg;

  localparam int PAGE_AW = 8;

  function automatic int page_idx_w(input int pages);
    return (pages > 1) ? $clog2(pages) : 1;
  endfunction

endpackage

// File: rtl/tx_buf_ram.sv
// ---------------------------------------------------------------------------
// tx_buf_ram -- simple dual-port frame storage, PAGES x 256 bytes, one clock.
// Ports:
//   clk        : clock
//   i_rst      : synchronous reset, clears only the read register (not RAM)
//   i_wr_en    : write strobe
//   i_wr_addr  : write address {page, offset}
//   i_wr_data  : write byte
//   i_rd_addr  : read address {page, offset}
//   o_rd_data  : registered read byte, one cycle after i_rd_addr
// A read and a write to the same address in one cycle return the old byte.
// ---------------------------------------------------------------------------
module tx_buf_ram
  import cdbus_pkg::*;
#(
  parameter int PAGES = 2,
  parameter int AW    = page_idx_w(PAGES) + PAGE_AW
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data
);

  logic [7:0] r_mem [0:PAGES*256-1];
  logic [7:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_rd_data <= 8'h00;
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/tx_frame_buf.sv
// ---------------------------------------------------------------------------
// tx_frame_buf -- multi-page transmit frame buffer.
// The host fills the page it owns (wr_page) and commits it with switch_req;
// committed pages form a circular queue drained by the transmitter, which
// reads the oldest one (rd_page) and releases it with read_done.
//
// Optional feature macro: CDBUS_TX_ABORT_EN (adds tx_abort port + flush).
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data : host byte write into wr_page
//   switch_req   : commit the host page
//   tx_abort     : flush every committed/pending page (macro only)
//   unread       : at least one committed page is waiting
//   addr / data  : transmitter read offset / registered read byte
//   read_done    : transmitter is finished with the current page
//   buf_free     : the next switch_req commits immediately
//   switch_pend  : a switch_req is waiting for a page to be released
//   cmt_cnt      : number of committed, unread pages
//   dbg_wr_page, dbg_rd_page : queue pointers, for observation only
//
// Handshake: switch_req, read_done and tx_abort are single-cycle pulses with
// no ready; each is acted on in the cycle it is high. A switch_req that
// cannot commit (queue full) is held as switch_pend and completes in the
// cycle a read_done frees a page; further switch_req while pending are
// dropped. read_done with nothing committed is dropped.
// ---------------------------------------------------------------------------
module tx_frame_buf
  import cdbus_pkg::*;
#(
  parameter  int PAGES = 2,
  localparam int PW    = page_idx_w(PAGES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          switch_req,
`ifdef CDBUS_TX_ABORT_EN
  input  logic          tx_abort,
`endif
  output logic          unread,
  input  logic [7:0]    addr,
  output logic [7:0]    data,
  input  logic          read_done,
  output logic          buf_free,
  output logic          switch_pend,
  output logic [PW-1:0] cmt_cnt,
  output logic [PW-1:0] dbg_wr_page,
  output logic [PW-1:0] dbg_rd_page
);

  localparam logic [PW-1:0] CNT_FULL = PW'(PAGES - 1);
  localparam logic [PW-1:0] ONE      = PW'(1);

  logic [PW-1:0] r_wr_page;
  logic [PW-1:0] r_rd_page;
  logic [PW-1:0] r_cmt_cnt;
  logic          r_switch_pend;

  logic          w_release;
  logic          w_full;
  logic          w_commit;
  logic          w_pend_nxt;

  function automatic logic [PW-1:0] next_page(input logic [PW-1:0] p);
    return (p == CNT_FULL) ? '0 : p + ONE;
  endfunction

  // A full queue can still take a new commit in the same cycle a page is
  // released, so the release is folded into the "room available" test.
  always_comb begin
    w_release  = read_done && (r_cmt_cnt != '0);
    w_full     = (r_cmt_cnt == CNT_FULL);
    w_commit   = 1'b0;
    w_pend_nxt = r_switch_pend;
    if (r_switch_pend) begin
      if (w_release) begin
        w_commit   = 1'b1;
        w_pend_nxt = 1'b0;
      end
    end else if (switch_req) begin
      if (!w_full || w_release) begin
        w_commit = 1'b1;
      end else begin
        w_pend_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_page     <= '0;
      r_rd_page     <= '0;
      r_cmt_cnt     <= '0;
      r_switch_pend <= 1'b0;
`ifdef CDBUS_TX_ABORT_EN
    end else if (tx_abort) begin
      // Flush: the reader jumps to the host page, so the queue is empty.
      r_rd_page     <= r_wr_page;
      r_cmt_cnt     <= '0;
      r_switch_pend <= 1'b0;
`endif
    end else begin
      if (w_commit) begin
        r_wr_page <= next_page(r_wr_page);
      end
      if (w_release) begin
        r_rd_page <= next_page(r_rd_page);
      end
      case ({w_commit, w_release})
        2'b10:   r_cmt_cnt <= r_cmt_cnt + ONE;
        2'b01:   r_cmt_cnt <= r_cmt_cnt - ONE;
        default: r_cmt_cnt <= r_cmt_cnt;
      endcase
      r_switch_pend <= w_pend_nxt;
    end
  end

  tx_buf_ram #(
    .PAGES (PAGES)
  ) u_ram (
    .clk       (clk),
    .i_rst     (reset),
    .i_wr_en   (wr_en),
    .i_wr_addr ({r_wr_page, wr_addr}),
    .i_wr_data (wr_data),
    .i_rd_addr ({r_rd_page, addr}),
    .o_rd_data (data)
  );

  assign unread      = (r_cmt_cnt != '0);
  assign buf_free    = (r_cmt_cnt < CNT_FULL) && !r_switch_pend;
  assign switch_pend = r_switch_pend;
  assign cmt_cnt     = r_cmt_cnt;
  assign dbg_wr_page = r_wr_page;
  assign dbg_rd_page = r_rd_page;

endmodule
